// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants and the buffered instruction entry type.
package fetch_pkg;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [2:0]  FUNCT3_WORD = 3'b010;
  localparam logic [31:0] STOP_WORD   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory read port, controller handshake and redirect bundle of the fetch stage.
interface instr_fetch_unit_if;

  logic [31:0] mem_read_address;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_read_data;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  // Fetch unit side.
  modport master (
    output mem_read_address, mem_funct3, instr_valid, instr_data, instr_pc, halted,
    input  mem_read_data, instr_ready, redirect_valid, redirect_pc
  );

  // Memory/controller side.
  modport slave (
    input  mem_read_address, mem_funct3, instr_valid, instr_data, instr_pc, halted,
    output mem_read_data, instr_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of {pc, instr} entries with synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int           DEPTH       = 4,
  parameter fetch_entry_t RESET_ENTRY = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_entry,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // Entry storage; reset contents define the head value seen while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_ENTRY;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // Pointers and occupancy; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC generation, one-deep in-flight tracking,
// credit-based issue into the fetch FIFO, stop-word halt and redirect.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | issuing while credits allow, capturing returned words
//   ST_HALT | stop word captured; no issue, stale responses dropped
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int              CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(DEPTH);

  fetch_state_t state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;

  logic             push;
  logic             pop;
  logic             room;
  logic [CNT_W-1:0] count;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  // Same-cycle pops are not credited, so buffered plus in-flight never exceeds DEPTH.
  assign room = ({1'b0, count} + {{CNT_W{1'b0}}, inflight_q}) < CREDITS;

  assign push_entry = '{pc: inflight_pc_q, instr: bus.mem_read_data};

  // State and fetch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Next state, issue, capture and pop; a redirect overrides everything else.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    push          = 1'b0;
    pop           = 1'b0;
    if (bus.redirect_valid) begin
      state_d    = ST_RUN;
      fetch_pc_d = bus.redirect_pc & ~32'h3;
    end else begin
      pop = (count != '0) && bus.instr_ready;
      case (state_q)
        ST_RUN: begin
          if (inflight_q) begin
            if (bus.mem_read_data == STOP_WORD) state_d = ST_HALT;
            else                                push    = 1'b1;
          end
          if (room) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + INSTR_BYTES;
          end
        end
        ST_HALT: begin
          // The response issued alongside the stop-word capture is discarded.
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH       (DEPTH),
    .RESET_ENTRY (fetch_entry_t'{pc: RESET_PC, instr: 32'h0})
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .push_entry (push_entry),
    .count      (count),
    .head       (head)
  );

  assign bus.mem_read_address = fetch_pc_q;
  assign bus.mem_funct3       = FUNCT3_WORD;
  assign bus.instr_valid      = (count != '0);
  assign bus.instr_data       = head.instr;
  assign bus.instr_pc         = head.pc;
  assign bus.halted           = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: straight-line fetch, backpressure,
// redirect, stop word, asynchronous reset and PC wrap.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ready;
  logic        rv;
  logic [31:0] rpc;
  logic        stop_en;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if bus0 ();
  instr_fetch_unit_if bus1 ();

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  assign bus0.instr_ready    = ready;
  assign bus0.redirect_valid = rv;
  assign bus0.redirect_pc    = rpc;
  assign bus1.instr_ready    = ready;
  assign bus1.redirect_valid = rv;
  assign bus1.redirect_pc    = rpc;

  // Memory contents: unique non-zero word per address, optional stop word at 0x0C.
  function automatic logic [31:0] word(input logic [31:0] a);
    if (stop_en && a == 32'h0000_000C) return 32'h0;
    return a + 32'h1000_0001;
  endfunction

  // Synchronous memory: data valid the cycle after the address.
  always @(posedge clk) begin
    bus0.mem_read_data <= word(bus0.mem_read_address);
    bus1.mem_read_data <= word(bus1.mem_read_address);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ready   = 1'b1;
    rv      = 1'b0;
    rpc     = 32'h0;
    stop_en = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);

    chk("rst_addr",    bus0.mem_read_address, 32'h0);
    chk("rst_funct3",  bus0.mem_funct3,       32'h2);
    chk("rst_valid",   bus0.instr_valid,      32'h0);
    chk("rst_data",    bus0.instr_data,       32'h0);
    chk("rst_pc",      bus0.instr_pc,         32'h0);
    chk("rst_halted",  bus0.halted,           32'h0);
    chk("rst_addr_w",  bus1.mem_read_address, 32'hFFFF_FFF8);
    chk("rst_pc_w",    bus1.instr_pc,         32'hFFFF_FFF8);
    rst_n = 1'b1;

    // Straight-line fetch; second instance checks PC wrap.
    step();
    chk("line_edge1_valid", bus0.instr_valid, 32'h0);
    step();
    for (int k = 0; k < 8; k++) begin
      chk("line_valid", bus0.instr_valid, 32'h1);
      chk("line_pc",    bus0.instr_pc,    32'(4 * k));
      chk("line_data",  bus0.instr_data,  word(32'(4 * k)));
      if (k < 4) begin
        chk("wrap_pc",   bus1.instr_pc,   32'hFFFF_FFF8 + 32'(4 * k));
        chk("wrap_data", bus1.instr_data, word(32'hFFFF_FFF8 + 32'(4 * k)));
      end
      step();
    end

    // Backpressure: four buffered, fetch PC frozen, head stable, then clean drain.
    ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i >= 2) chk("bp_head_stable", bus0.instr_pc, 32'h0);
    end
    chk("bp_valid", bus0.instr_valid,      32'h1);
    chk("bp_addr",  bus0.mem_read_address, 32'h10);
    chk("bp_data",  bus0.instr_data,       word(32'h0));
    ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("bp_drain_valid", bus0.instr_valid, 32'h1);
      chk("bp_drain_pc",    bus0.instr_pc,    32'(4 * k));
      step();
    end

    // Redirect mid-stream to an unaligned PC.
    ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("rd_pre_pc", bus0.instr_pc, 32'hC);
    rv  = 1'b1;
    rpc = 32'h43;
    step();
    rv = 1'b0;
    chk("rd_flush_valid", bus0.instr_valid, 32'h0);
    step();
    chk("rd_gap_valid", bus0.instr_valid,      32'h0);
    chk("rd_gap_addr",  bus0.mem_read_address, 32'h44);
    step();
    chk("rd_new_valid", bus0.instr_valid, 32'h1);
    chk("rd_new_pc",    bus0.instr_pc,    32'h40);
    chk("rd_new_data",  bus0.instr_data,  word(32'h40));
    step();
    chk("rd_pc_44", bus0.instr_pc, 32'h44);
    step();
    chk("rd_pc_48", bus0.instr_pc, 32'h48);

    // Stop word at 0x0C.
    stop_en = 1'b1;
    do_reset();
    step();
    step();
    chk("stop_pc0", bus0.instr_pc, 32'h0);
    step();
    chk("stop_pc4", bus0.instr_pc, 32'h4);
    step();
    chk("stop_pc8",     bus0.instr_pc, 32'h8);
    chk("stop_pre_hlt", bus0.halted,   32'h0);
    step();
    chk("stop_halted", bus0.halted,      32'h1);
    chk("stop_valid",  bus0.instr_valid, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stop_hold_valid", bus0.instr_valid,      32'h0);
      chk("stop_hold_hlt",   bus0.halted,           32'h1);
      chk("stop_hold_addr",  bus0.mem_read_address, 32'h14);
    end
    rv  = 1'b1;
    rpc = 32'h0;
    step();
    rv = 1'b0;
    chk("stop_rd_halted", bus0.halted,      32'h0);
    chk("stop_rd_valid",  bus0.instr_valid, 32'h0);
    step();
    step();
    chk("stop_re_valid", bus0.instr_valid, 32'h1);
    chk("stop_re_pc0",   bus0.instr_pc,    32'h0);
    step();
    chk("stop_re_pc4",   bus0.instr_pc,    32'h4);
    stop_en = 1'b0;

    // Asynchronous reset with three entries buffered.
    ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    chk("ar_pre_valid", bus0.instr_valid, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid",  bus0.instr_valid,      32'h0);
    chk("ar_addr",   bus0.mem_read_address, 32'h0);
    chk("ar_data",   bus0.instr_data,       32'h0);
    chk("ar_halted", bus0.halted,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    step();
    chk("ar_restart_valid", bus0.instr_valid, 32'h1);
    chk("ar_restart_pc",    bus0.instr_pc,    32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage upstream of the `controller` decode/execute block. Drives the memory module's read port, buffers returned 32-bit instruction words with their PCs in a small FIFO, and presents them to the controller over a valid/ready handshake. Handles PC redirects (flush and refetch) and stops fetching when the all-zero stop word is fetched.

## Interface

- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word aligned.

- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `mem_read_address`, out, 32: registered word address to memory.
- `mem_funct3`, out, 3: constant 3'b010 (full-word read).
- `mem_read_data`, in, 32: memory data; valid the cycle after the address is presented.
- `instr_valid`, out, 1: FIFO head holds an instruction.
- `instr_data`, out, 32: instruction at the FIFO head.
- `instr_pc`, out, 32: PC of `instr_data`.
- `instr_ready`, in, 1: controller accepts the head this cycle.
- `redirect_valid`, in, 1: one-cycle pulse; flush and refetch from `redirect_pc`.
- `redirect_pc`, in, 32: new fetch PC; bits [1:0] are forced to 0.
- `halted`, out, 1: stop word seen; no further issue.

## Operation

- **Issue.** Each cycle with `!halted`, no redirect, and `count + inflight < DEPTH`:
  - present `fetch_pc` on `mem_read_address`;
  - set `inflight=1`, `inflight_pc=fetch_pc`;
  - `fetch_pc += 4` (mod 2^32; wrap from 32'hFFFF_FFFC to 0 is legal).
  - Otherwise `inflight` clears.
- **Capture.** In the cycle after an issue, `mem_read_data` is sampled:
  - If it is non-zero, push `{inflight_pc, mem_read_data}` into the FIFO.
  - If it equals 32'h0, do not push it. Set `halted=1`. Issue stops. Words already in the FIFO still drain.
- **Pop.** Occurs when `instr_valid && instr_ready` with no redirect.
- **Simultaneous push and pop.** Both happen; `count` is unchanged. The credit check ignores same-cycle pops, so the FIFO never overflows.
- **Redirect.** Takes priority over everything else in that cycle:
  - flush the FIFO (`count=0`);
  - drop any inflight response;
  - any pop that cycle is void;
  - clear `halted`;
  - set `fetch_pc = {redirect_pc[31:2], 2'b00}`.
  - Issue resumes the following cycle.
- **Reset mid-operation.** Immediately returns all state to reset values. In-flight memory data is discarded.

## Timing

- **Reset values:**
  - `mem_read_address = RESET_PC`
  - `mem_funct3 = 3'b010`
  - `instr_valid = 0`, `instr_data = 0`, `instr_pc = RESET_PC`
  - `halted = 0`
  - `fetch_pc = RESET_PC`, `inflight = 0`, `count = 0`
- **First fetch after `rst_n` rises:**
  - edge 1 issues `RESET_PC`;
  - edge 2 captures the data;
  - `instr_valid=1` after edge 2.
- **Latency:** issue to `instr_valid` is 2 edges. Redirect to first new `instr_valid` is 3 edges.
- **Throughput:** one instruction per cycle sustained while `instr_ready=1`. With `DEPTH=4` and `instr_ready=0`, at most 4 words are buffered plus 0 in flight; issue stalls.
- **Output stability:** `instr_data` and `instr_pc` are stable while `instr_valid && !instr_ready`. They change only on pop, on redirect, or on push into an empty FIFO.
- **Halt:** `halted` rises at the edge that captures the zero word. A redirect in the same cycle as that capture wins, and `halted` stays 0.

## Structure

- **Package `fetch_pkg`:**
  - `INSTR_BYTES = 4`
  - `FUNCT3_WORD = 3'b010`
  - `STOP_WORD = 32'h0`
  - packed struct `fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}`
  - The package is shared with `controller` for the stop-word and funct3 constants.
- **Sub-module `fetch_fifo`:**
  - parameterised by `DEPTH`, storing `fetch_entry_t`;
  - ports: push, pop, flush, count, head;
  - synchronous flush and asynchronous active-low reset.
- **Top level:** `instr_fetch_unit` holds `fetch_pc`, the inflight register, halt logic and credit logic.

## Test plan

- **Straight-line fetch.** Memory holds 8 non-zero words at 0x00–0x1C; `instr_ready=1`.
  - Expect PCs 0x00, 0x04, … 0x1C on consecutive cycles starting 2 edges after reset.
- **Backpressure.** Hold `instr_ready=0` for 10 cycles.
  - Expect exactly 4 entries buffered, `mem_read_address` frozen at 0x10, and the head stable at PC 0x00.
  - Release; expect no gaps or duplicates.
- **Redirect.** Pulse `redirect_valid` with `redirect_pc=0x43` mid-stream.
  - Expect the next `instr_pc` to be 0x40 after 3 edges.
  - Expect no pre-redirect instruction to appear afterwards, including the one in flight.
- **Stop word.** Word at 0x0C is 32'h0.
  - Expect 0x00–0x08 delivered, `halted=1`, and no issue beyond 0x10.
  - Redirect to 0x00; expect `halted=0` and refetch from 0x00.
- **Asynchronous reset.** Assert `rst_n=0` mid-cycle while the FIFO holds 3 entries.
  - Expect `instr_valid=0` and `mem_read_address=RESET_PC` immediately, without waiting for a clock edge.
- **PC wrap.** Set `RESET_PC=32'hFFFF_FFF8`.
  - Expect PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
